// File: rtl/maxpool_stage_if.sv
// Beat streams of the max-pooling stage: input beats from bias/ReLU, pooled beats to write-back.
// master = upstream/downstream environment, slave = the pooling stage itself.
interface maxpool_stage_if #(
  parameter int BUSWIDTH = 512
) ();
  logic [BUSWIDTH-1:0] Data_i;
  logic                Data_en_i;
  logic                Data_rdy_o;
  logic [BUSWIDTH-1:0] Result_o;
  logic                Result_vld_o;
  logic                Result_rdy_i;

  modport master (
    output Data_i, Data_en_i, Result_rdy_i,
    input  Data_rdy_o, Result_o, Result_vld_o
  );

  modport slave (
    input  Data_i, Data_en_i, Result_rdy_i,
    output Data_rdy_o, Result_o, Result_vld_o
  );
endinterface

// File: rtl/maxpool_stage.sv
// Vertical max-pooling over a run-time number of beats, signed 32-bit lanes.
// Optional horizontal 2:1 pooling of the result when HPOOL_EN is defined.
module maxpool_stage #(
  parameter int BUSWIDTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Pool_Start_i,
  input  logic [3:0]  Pool_Len_i,
  input  logic [15:0] Out_Num_i,
  output logic        Pool_Done_o,
  maxpool_stage_if.slave bus
);
  localparam int LANES = BUSWIDTH / 32;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t              state;
  logic [3:0]          len;
  logic [3:0]          beat_cnt;
  logic [15:0]         out_num;
  logic [15:0]         out_cnt;
  logic [BUSWIDTH-1:0] acc;
  logic [BUSWIDTH-1:0] acc_next;
  logic [3:0]          len_clamped;
  logic                data_rdy;
  logic                result_vld;
  logic                done;
  logic                beat_fire;
  logic                out_fire;

  assign beat_fire = data_rdy & bus.Data_en_i;
  assign out_fire  = result_vld & bus.Result_rdy_i;

  always_comb begin
    len_clamped = Pool_Len_i;
    if (Pool_Len_i == 4'd0)     len_clamped = 4'd1;
    else if (Pool_Len_i > 4'd8) len_clamped = 4'd8;
  end

  // First beat of a group overwrites the accumulator; later beats take the lane-wise signed max.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred for lanes left untouched.
    acc_next = acc;
    for (int k = 0; k < LANES; k++) begin
      if (beat_cnt == 4'd0)
        acc_next[32*k +: 32] = bus.Data_i[32*k +: 32];
      else if ($signed(bus.Data_i[32*k +: 32]) > $signed(acc[32*k +: 32]))
        acc_next[32*k +: 32] = bus.Data_i[32*k +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= 4'd0;
      beat_cnt   <= 4'd0;
      out_num    <= 16'd0;
      out_cnt    <= 16'd0;
      // NOTE: acc is reset explicitly because Result_o must read zero after reset.
      acc        <= '0;
      data_rdy   <= 1'b0;
      result_vld <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees the pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Pool_Start_i) begin
            len      <= len_clamped;
            out_num  <= Out_Num_i;
            beat_cnt <= 4'd0;
            out_cnt  <= 16'd0;
            if (Out_Num_i == 16'd0) begin
              done <= 1'b1;
            end else begin
              state    <= ACC;
              data_rdy <= 1'b1;
            end
          end
        end
        ACC: begin
          if (beat_fire) begin
            acc <= acc_next;
            if (beat_cnt == len - 4'd1) begin
              beat_cnt   <= 4'd0;
              state      <= OUT;
              data_rdy   <= 1'b0;
              result_vld <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            out_cnt    <= out_cnt + 16'd1;
            result_vld <= 1'b0;
            if (out_cnt + 16'd1 == out_num) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state    <= ACC;
              data_rdy <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          data_rdy   <= 1'b0;
          result_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Data_rdy_o   = data_rdy;
  assign bus.Result_vld_o = result_vld;
  assign Pool_Done_o      = done;

`ifdef HPOOL_EN
  // Pairs of adjacent lanes fold into the lower half; the upper half reads zero.
  always_comb begin
    bus.Result_o = '0;
    for (int j = 0; j < LANES / 2; j++) begin
      if ($signed(acc[64*j +: 32]) > $signed(acc[64*j + 32 +: 32]))
        bus.Result_o[32*j +: 32] = acc[64*j +: 32];
      else
        bus.Result_o[32*j +: 32] = acc[64*j + 32 +: 32];
    end
  end
`else
  assign bus.Result_o = acc;
`endif

endmodule

// File: doc/maxpool_stage.md
# maxpool_stage

Vertical max-pooling stage that sits directly downstream of the bias/ReLU stage in the CNN accelerator datapath. It consumes BUSWIDTH-wide result beats (BUSWIDTH/32 signed 32-bit lanes), takes the lane-wise maximum over a run-time number of consecutive beats, and emits one pooled beat per group over a valid/ready handshake toward the write-back master. A start/done pair matches the start/done control used by the other compute stages.

## Interface
- BUSWIDTH, 512: data bus width; a multiple of 32; lane count L = BUSWIDTH/32.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Pool_Start_i  in  1  one-cycle pulse; latches Pool_Len_i and Out_Num_i; honoured only in IDLE.
- Pool_Len_i  in  4  beats per pooling group, 1..8; 0 is treated as 1; values above 8 clamp to 8.
- Out_Num_i  in  16  pooled beats to produce in this run.
- Data_i  in  BUSWIDTH  input beat, L signed 32-bit lanes, lane k = Data_i[32k+31:32k].
- Data_en_i  in  1  input valid.
- Data_rdy_o  out  1  input ready; beat accepted when Data_en_i && Data_rdy_o.
- Result_o  out  BUSWIDTH  pooled beat.
- Result_vld_o  out  1  output valid.
- Result_rdy_i  in  1  output ready; beat transferred when Result_vld_o && Result_rdy_i.
- Pool_Done_o  out  1  one-cycle pulse at end of run.

## Operation
- States: IDLE, ACC, OUT. Reset -> IDLE.
- IDLE: Data_rdy_o=0, Result_vld_o=0. Pool_Start_i -> latch len (clamped), out_num; clear beat_cnt, out_cnt. If Out_Num_i==0 -> Pool_Done_o next cycle, remain IDLE; else -> ACC.
- ACC: Data_rdy_o=1. Each accepted beat: beat_cnt==0 loads acc<=Data_i; otherwise acc[k]<=max(acc[k],Data_i[k]) per lane, signed 32-bit compare. On the beat where beat_cnt==len-1: beat_cnt<=0, -> OUT. Else beat_cnt++.
- OUT: Data_rdy_o=0, Result_vld_o=1, Result_o=acc (registered, stable until transfer). On transfer: out_cnt++; if out_cnt+1==out_num -> Pool_Done_o pulse next cycle, -> IDLE; else -> ACC.
- Pool_Start_i in ACC/OUT ignored; no effect on counters or latched config.
- Data_en_i without Data_rdy_o: ignored, no state change.
- Equal lanes: either value (identical). Most negative (0x80000000) is a valid operand.

## Timing
- Reset values: Data_rdy_o=0, Result_vld_o=0, Result_o=0, Pool_Done_o=0; acc, counters zero.
- Data_rdy_o and Result_vld_o are registered state decodes; neither depends combinationally on Data_en_i or Result_rdy_i.
- Latency: Result_vld_o rises the cycle after the last beat of a group is accepted.
- Throughput: len accept cycles + at least 1 OUT cycle per group; with Result_rdy_i held high, one pooled beat every len+1 cycles.
- Backpressure: Result_rdy_i low holds OUT indefinitely; Result_o/Result_vld_o stable.
- Pool_Done_o: exactly one cycle, the cycle after the final transfer, coincident with IDLE; Pool_Start_i accepted in that same cycle.
- rst mid-run: next cycle IDLE with all outputs at reset values; partial group discarded, no Done.

## Configuration
- HPOOL_EN defined: after vertical max, Result_o also applies horizontal 2:1 pooling. Lane j (j<L/2) = max(acc[2j],acc[2j+1]); lanes L/2..L-1 = 0. Pooling is combinational off acc, same latency.
- HPOOL_EN undefined: Result_o = acc lane-for-lane; no horizontal logic synthesised.

## Test plan
- Len=2, Out_Num=1, beats lane0=5 then -3, lane1=-7 then 9, Result_rdy_i=1 -> Result_o lane0=5, lane1=9, valid 1 cycle after 2nd beat; Done next cycle.
- Len=4, Out_Num=3, continuous Data_en_i, ready=1 -> 3 pooled beats, spaced 5 cycles; Data_rdy_o low each OUT cycle; single Done.
- Result_rdy_i low 10 cycles in OUT -> Result_o stable, Data_rdy_o=0, no beats consumed; transfer on ready rise.
- Pool_Len_i=0 and Out_Num_i=0 -> len 0 behaves as 1 (passthrough per beat); Out_Num 0 -> Done 1 cycle after start, no Result_vld_o.
- rst asserted after 1st of 4 beats, then new start with len=1 -> no stale data; first result equals first new beat.
- HPOOL_EN, len=1, lanes {0x80000000,-1,3,2,...} -> lane0=-1, lane1=3, upper half zero.
